// File: rtl/fs_accel_pu_array_seq_if.sv
// Handshake bundle for the PU array: weight-set writes, window updates and result stream.
interface fs_accel_pu_array_seq_if #(
  parameter int NUM_PU = 3,
  parameter int K      = 3,
  parameter int DW     = 8,
  parameter int ACC_W  = 32
);
  localparam int IDX_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  logic                    wgt_vld;
  logic                    wgt_rdy;
  logic [IDX_W-1:0]        wgt_pu_idx;
  logic [K*K*DW-1:0]       wgt_data;

  logic                    in_vld;
  logic                    in_rdy;
  logic [1:0]              in_dir;
  logic [K*K*DW-1:0]       in_data;

  logic                    out_vld;
  logic                    out_rdy;
  logic [NUM_PU*ACC_W-1:0] out_data;

  modport master (
    output wgt_vld, wgt_pu_idx, wgt_data, in_vld, in_dir, in_data, out_rdy,
    input  wgt_rdy, in_rdy, out_vld, out_data
  );

  modport slave (
    input  wgt_vld, wgt_pu_idx, wgt_data, in_vld, in_dir, in_data, out_rdy,
    output wgt_rdy, in_rdy, out_vld, out_data
  );
endinterface

// File: rtl/fs_accel_pu_array_seq.sv
// Self-sequenced KxK PU array: holds a shiftable input window and NUM_PU weight sets,
// runs a row-serial MAC (one window row per cycle) and presents one result per PU.
module fs_accel_pu_array_seq #(
  parameter int NUM_PU = 3,
  parameter int K      = 3,
  parameter int DW     = 8,
  parameter int ACC_W  = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cfg_is_conv,
  input  logic [31:0]            cfg_input_offset,
  fs_accel_pu_array_seq_if.slave bus,
  output logic                   busy,
  output logic                   err_idx
);
  localparam int IDX_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;
  localparam int ROW_W = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] DIR_NON   = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  typedef logic signed [DW-1:0] elem_t;

  state_t                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  elem_t                   win_q [K][K];
  elem_t                   win_d [K][K];
  elem_t                   wgt_q [NUM_PU][K][K];
  elem_t                   wgt_d [NUM_PU][K][K];
  logic signed [ACC_W-1:0] acc_q [NUM_PU];
  logic signed [ACC_W-1:0] acc_d [NUM_PU];
  logic signed [ACC_W-1:0] row_sum [NUM_PU];
  logic                    err_q, err_d;
  logic                    wgt_acc, in_acc;

  // Weight writes win over window updates when both are offered in IDLE.
  assign bus.wgt_rdy = (state_q == IDLE);
  assign bus.in_rdy  = (state_q == IDLE) && !bus.wgt_vld;
  assign wgt_acc     = bus.wgt_vld && bus.wgt_rdy;
  assign in_acc      = bus.in_vld && bus.in_rdy;

  assign bus.out_vld = (state_q == OUT);
  assign busy        = (state_q != IDLE);
  assign err_idx     = err_q;

  // Results are exposed straight from the accumulators; stable in OUT because nothing accumulates there.
  always_comb begin
    bus.out_data = '0;
    for (int p = 0; p < NUM_PU; p++) bus.out_data[p*ACC_W +: ACC_W] = acc_q[p];
  end

  // One window row per PU: arithmetic done modulo 2^ACC_W, which equals truncating the full-precision sum.
  always_comb begin
    for (int p = 0; p < NUM_PU; p++) begin
      row_sum[p] = '0;
      for (int c = 0; c < K; c++) begin
        row_sum[p] = row_sum[p] + ACC_W'(wgt_q[p][row_q][c]) *
                     (ACC_W'(win_q[row_q][c]) + ACC_W'($signed(cfg_input_offset)));
      end
    end
  end

  // Weight-set writes; an out-of-range PU index writes nothing and latches the error flag.
  always_comb begin
    wgt_d = wgt_q;
    err_d = err_q;
    if (wgt_acc) begin
      if (int'(bus.wgt_pu_idx) >= NUM_PU) err_d = 1'b1;
      for (int p = 0; p < NUM_PU; p++) begin
        if (bus.wgt_pu_idx == IDX_W'(p)) begin
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              wgt_d[p][r][c] = bus.wgt_data[(r*K+c)*DW +: DW];
        end
      end
    end
  end

  // Window update: full load in FC mode or for NON, otherwise a one-row/column shift onto old contents.
  always_comb begin
    win_d = win_q;
    if (in_acc) begin
      if (!cfg_is_conv || bus.in_dir == DIR_NON) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            win_d[r][c] = bus.in_data[(r*K+c)*DW +: DW];
      end else begin
        case (bus.in_dir)
          DIR_RIGHT: begin
            for (int r = 1; r < K; r++) win_d[r] = win_q[r-1];
            for (int c = 0; c < K; c++) win_d[0][c] = bus.in_data[c*DW +: DW];
          end
          DIR_LEFT: begin
            for (int r = 0; r < K-1; r++) win_d[r] = win_q[r+1];
            for (int c = 0; c < K; c++) win_d[K-1][c] = bus.in_data[c*DW +: DW];
          end
          DIR_DOWN: begin
            for (int r = 0; r < K; r++) begin
              for (int c = 0; c < K-1; c++) win_d[r][c] = win_q[r][c+1];
              win_d[r][K-1] = bus.in_data[r*DW +: DW];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Sequencer: IDLE -> MAC (K rows) -> OUT -> IDLE on result handshake.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (in_acc) begin
          state_d = MAC;
          row_d   = '0;
          for (int p = 0; p < NUM_PU; p++) acc_d[p] = '0;
        end
      end
      MAC: begin
        for (int p = 0; p < NUM_PU; p++) acc_d[p] = acc_q[p] + row_sum[p];
        if (row_q == ROW_W'(K-1)) state_d = OUT;
        else                      row_d   = row_q + 1'b1;
      end
      OUT: begin
        if (bus.out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears everything and aborts any operation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      row_q   <= '0;
      win_q   <= '{default: '0};
      wgt_q   <= '{default: '0};
      acc_q   <= '{default: '0};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      win_q   <= win_d;
      wgt_q   <= wgt_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end
endmodule
